// File: rtl/digit_pkg.sv
// Shared definitions for the cascaded timer digits: mode codes, FSM states,
// digit width and the fallback maximum used when max_value is left at 0.
package digit_pkg;

  localparam int DIGIT_WIDTH = 4;
  localparam logic [DIGIT_WIDTH-1:0] DIGIT_MAX_DEFAULT = 4'd9;

  localparam logic [3:0] ST_RESET = 4'd0;
  localparam logic [3:0] ST_SET   = 4'd1;
  localparam logic [3:0] ST_HOLD  = 4'd2;
  localparam logic [3:0] ST_START = 4'd3;

  typedef logic [DIGIT_WIDTH-1:0] digit_w_t;

  typedef enum logic [1:0] {
    S_RESET,
    S_SET,
    S_HOLD,
    S_RUN
  } fsm_state_t;

endpackage

// File: rtl/carry_edge_detect.sv
// Falling-edge detector for the carry level coming from the lower digit.
// Define CARRY_SYNC_EN to insert a 2-flop synchronizer ahead of the detector.
module carry_edge_detect (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_carry_in,
  output logic o_carry_eff,
  output logic o_event
);

  logic w_carryEff;
  logic r_carryQ;

`ifdef CARRY_SYNC_EN
  logic [1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], i_carry_in};
    end
  end

  assign w_carryEff = r_sync[1];
`else
  assign w_carryEff = i_carry_in;
`endif

  // Sampled in every mode so entering run with carry already high is not an edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_carryQ <= 1'b0;
    end else begin
      r_carryQ <= w_carryEff;
    end
  end

  assign o_carry_eff = w_carryEff;
  assign o_event     = r_carryQ & ~w_carryEff;

endmodule

// File: rtl/digit_module_upper.sv
// Upper digit of the cascaded timer: counts carry falling edges from the digit
// below and forwards its own carry level upward. CARRY_SYNC_EN adds input sync.
module digit_module_upper
  import digit_pkg::*;
#(
  parameter int                WIDTH       = DIGIT_WIDTH,
  parameter logic [WIDTH-1:0]  MAX_DEFAULT = DIGIT_MAX_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [3:0]       i_state,
  input  logic [WIDTH-1:0] i_set_value,
  input  logic [WIDTH-1:0] i_max_value,
  input  logic             i_carry_in,
  output logic [WIDTH-1:0] o_digit_out,
  output logic             o_carry_out,
  output logic             o_wrap_pulse
);

  logic             w_carryEff;
  logic             w_event;
  fsm_state_t       r_state;
  fsm_state_t       w_stateNext;
  logic [WIDTH-1:0] r_digit;
  logic [WIDTH-1:0] w_digitNext;
  logic [WIDTH-1:0] w_effMax;
  logic [WIDTH:0]   w_sum;
  logic             w_wrapNext;
  logic             w_carryOutNext;
  logic             r_carryOut;
  logic             r_wrap;

  carry_edge_detect u_carry_edge_detect (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_carry_in  (i_carry_in),
    .o_carry_eff (w_carryEff),
    .o_event     (w_event)
  );

  assign w_effMax = (i_max_value == '0) ? MAX_DEFAULT : i_max_value;
  assign w_sum    = {1'b0, r_digit} + (WIDTH+1)'(1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_RESET;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Run cannot jump straight to set; unlisted mode codes behave as hold.
  always_comb begin
    w_stateNext = r_state;
    if (i_state == ST_RESET) begin
      w_stateNext = S_RESET;
    end else begin
      case (r_state)
        S_RESET: begin
          if (i_state == ST_SET)        w_stateNext = S_SET;
          else if (i_state == ST_START) w_stateNext = S_RUN;
        end
        S_SET: begin
          if (i_state == ST_START)      w_stateNext = S_RUN;
          else if (i_state != ST_SET)   w_stateNext = S_HOLD;
        end
        S_RUN: begin
          if (i_state != ST_START && i_state != ST_SET) w_stateNext = S_HOLD;
        end
        S_HOLD: begin
          if (i_state == ST_START)      w_stateNext = S_RUN;
        end
        default: w_stateNext = S_RESET;
      endcase
    end
  end

  // Actions follow the mode being entered, so reset or hold in the event cycle wins.
  always_comb begin
    w_digitNext = r_digit;
    w_wrapNext  = 1'b0;
    case (w_stateNext)
      S_RESET: w_digitNext = '0;
      S_SET:   w_digitNext = (i_set_value > w_effMax) ? w_effMax : i_set_value;
      S_RUN: begin
        if (w_event) begin
          if (r_digit >= w_effMax) begin
            w_digitNext = '0;
            w_wrapNext  = 1'b1;
          end else begin
            w_digitNext = w_sum[WIDTH-1:0];
          end
        end
      end
      default: w_digitNext = r_digit;
    endcase
    w_carryOutNext = ((w_stateNext == S_RUN) || (w_stateNext == S_HOLD)) &&
                     (w_digitNext == w_effMax) && w_carryEff;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_digit    <= '0;
      r_carryOut <= 1'b0;
      r_wrap     <= 1'b0;
    end else begin
      r_digit    <= w_digitNext;
      r_carryOut <= w_carryOutNext;
      r_wrap     <= w_wrapNext;
    end
  end

  assign o_digit_out  = r_digit;
  assign o_carry_out  = r_carryOut;
  assign o_wrap_pulse = r_wrap;

endmodule

// File: tb/tb_digit_module_upper.sv
// Bench for digit_module_upper: a cycle model of the digit rules checked every
// negedge, plus directed scenarios with literal expectations (honours CARRY_SYNC_EN).
module tb_digit_module_upper;

`ifdef CARRY_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] state = 4'd0;
  logic [3:0] setValue = 4'd0;
  logic [3:0] maxValue = 4'd9;
  logic       carryIn = 1'b0;
  logic [3:0] digitOut;
  logic       carryOut;
  logic       wrapPulse;

  int checks = 0;
  int errors = 0;

  int mDigit = 0;
  int mMode = 0;
  int mPrev = 0;
  int mS1 = 0;
  int mS2 = 0;
  int mCarryOut = 0;
  int mWrap = 0;
  int mEff;
  int mCe;

  int expSeq[10] = '{1, 2, 3, 4, 5, 0, 1, 2, 3, 4};
  int wrapCount;

  digit_module_upper dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_state      (state),
    .i_set_value  (setValue),
    .i_max_value  (maxValue),
    .i_carry_in   (carryIn),
    .o_digit_out  (digitOut),
    .o_carry_out  (carryOut),
    .o_wrap_pulse (wrapPulse)
  );

  always #5 clk = ~clk;

  // Mode 0=reset 1=set 2=hold 3=run; digit value tracked as a plain integer.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mDigit = 0; mMode = 0; mPrev = 0; mS1 = 0; mS2 = 0; mCarryOut = 0; mWrap = 0;
    end else begin
      mEff = (maxValue == 0) ? 9 : int'(maxValue);
`ifdef CARRY_SYNC_EN
      mCe = mS2;
      mS2 = mS1;
      mS1 = int'(carryIn);
`else
      mCe = int'(carryIn);
`endif
      if (state == 0)      mMode = 0;
      else if (state == 3) mMode = 3;
      else if (state == 1) mMode = (mMode <= 1) ? 1 : mMode;
      else                 mMode = (mMode == 0) ? 0 : 2;
      mWrap = 0;
      if (mMode == 0) begin
        mDigit = 0;
      end else if (mMode == 1) begin
        mDigit = (int'(setValue) > mEff) ? mEff : int'(setValue);
      end else if (mMode == 3 && mPrev == 1 && mCe == 0) begin
        if (mDigit >= mEff) begin
          mDigit = 0;
          mWrap = 1;
        end else begin
          mDigit = mDigit + 1;
        end
      end
      mPrev = mCe;
      mCarryOut = (mMode >= 2 && mDigit == mEff && mCe == 1) ? 1 : 0;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("model digit_out", int'(digitOut), mDigit);
    checkOutput("model carry_out", int'(carryOut), mCarryOut);
    checkOutput("model wrap_pulse", int'(wrapPulse), mWrap);
  end

  task automatic applyStimulus(input logic [3:0] st, input logic [3:0] sv,
                               input logic [3:0] mv, input logic ci);
    state    = st;
    setValue = sv;
    maxValue = mv;
    carryIn  = ci;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset digit_out", int'(digitOut), 0);
    checkOutput("reset carry_out", int'(carryOut), 0);
    checkOutput("reset wrap_pulse", int'(wrapPulse), 0);
    rst_n = 1'b1;

    applyStimulus(4'd1, 4'd4, 4'd9, 1'b0);
    checkOutput("set value 4", int'(digitOut), 4);
    applyStimulus(4'd1, 4'd12, 4'd9, 1'b0);
    checkOutput("set clamp 12 to 9", int'(digitOut), 9);

    applyStimulus(4'd3, 4'd12, 4'd9, 1'b0);
    checkOutput("run entry digit", int'(digitOut), 9);
    checkOutput("run entry carry_out", int'(carryOut), 0);
    repeat (5) applyStimulus(4'd3, 4'd12, 4'd9, 1'b1);
    checkOutput("carry window carry_out", int'(carryOut), 1);
    checkOutput("carry window digit", int'(digitOut), 9);
    repeat (LAT) applyStimulus(4'd3, 4'd12, 4'd9, 1'b0);
    checkOutput("wrap digit", int'(digitOut), 0);
    checkOutput("wrap pulse high", int'(wrapPulse), 1);
    checkOutput("carry_out after fall", int'(carryOut), 0);
    applyStimulus(4'd3, 4'd12, 4'd9, 1'b0);
    checkOutput("wrap pulse one cycle", int'(wrapPulse), 0);

    // Max lowered to 5: ten carry pulses walk the digit through one wrap.
    wrapCount = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(4'd3, 4'd0, 4'd5, 1'b1);
      repeat (LAT) applyStimulus(4'd3, 4'd0, 4'd5, 1'b0);
      checkOutput($sformatf("max5 step %0d", i), int'(digitOut), expSeq[i]);
      if (wrapPulse === 1'b1) wrapCount++;
    end
    checkOutput("max5 wrap count", wrapCount, 1);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'd2, 4'd0, 4'd5, 1'b1);
      repeat (LAT) applyStimulus(4'd2, 4'd0, 4'd5, 1'b0);
    end
    checkOutput("hold ignores pulses", int'(digitOut), 4);
    repeat (LAT + 1) applyStimulus(4'd2, 4'd0, 4'd5, 1'b1);
    repeat (LAT + 1) applyStimulus(4'd3, 4'd0, 4'd5, 1'b1);
    checkOutput("no event on resume", int'(digitOut), 4);
    repeat (LAT) applyStimulus(4'd3, 4'd0, 4'd5, 1'b0);
    checkOutput("count after resume", int'(digitOut), 5);

    repeat (LAT) applyStimulus(4'd3, 4'd0, 4'd5, 1'b1);
    repeat (LAT - 1) applyStimulus(4'd3, 4'd0, 4'd5, 1'b0);
    applyStimulus(4'd2, 4'd0, 4'd5, 1'b0);
    checkOutput("event dropped on run to hold", int'(digitOut), 5);
    applyStimulus(4'd3, 4'd0, 4'd5, 1'b0);
    checkOutput("dropped event not queued", int'(digitOut), 5);

    repeat (LAT) applyStimulus(4'd3, 4'd0, 4'd9, 1'b1);
    repeat (LAT - 1) applyStimulus(4'd3, 4'd0, 4'd9, 1'b0);
    applyStimulus(4'd0, 4'd0, 4'd9, 1'b0);
    checkOutput("reset wins over event", int'(digitOut), 0);

    // Async reset must clear outputs between clock edges.
    applyStimulus(4'd1, 4'd7, 4'd7, 1'b0);
    applyStimulus(4'd3, 4'd7, 4'd7, 1'b0);
    repeat (LAT) applyStimulus(4'd3, 4'd7, 4'd7, 1'b1);
    checkOutput("pre-reset digit", int'(digitOut), 7);
    checkOutput("pre-reset carry_out", int'(carryOut), 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async reset digit", int'(digitOut), 0);
    checkOutput("async reset carry_out", int'(carryOut), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (LAT) applyStimulus(4'd3, 4'd7, 4'd7, 1'b1);
    repeat (LAT) applyStimulus(4'd3, 4'd7, 4'd7, 1'b0);
    checkOutput("count after reset release", int'(digitOut), 1);

    repeat (3) applyStimulus(4'd3, 4'd0, 4'd7, 1'b1);
`ifdef CARRY_SYNC_EN
    applyStimulus(4'd3, 4'd0, 4'd7, 1'b0);
    checkOutput("sync latency edge 1", int'(digitOut), 1);
    applyStimulus(4'd3, 4'd0, 4'd7, 1'b0);
    checkOutput("sync latency edge 2", int'(digitOut), 1);
    applyStimulus(4'd3, 4'd0, 4'd7, 1'b0);
    checkOutput("sync latency edge 3", int'(digitOut), 2);
`else
    applyStimulus(4'd3, 4'd0, 4'd7, 1'b0);
    checkOutput("direct latency edge 1", int'(digitOut), 2);
`endif

    repeat (3) applyStimulus(4'd3, 4'd0, 4'd7, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
